spi_line_streamer: RTL

Streams one 1bpp scanline per video line from an SPI flash (READ 0x03, SPI mode 0) directly onto the pixel output, with no line buffer. It sits directly downstream of `vga_sync` and consumes its `hpos` and `vpos` counters. Each line's read transaction is launched during the preceding HBLANK, timed so that the first data bit lands exactly on `hpos` = 0. Its `rgb` output feeds the top-level colour mux and the registered sync outputs.

---
 rtl/vga_spi_pkg.sv | 13 +
 rtl/spi_bit_engine.sv | 50 +++++
 rtl/spi_line_streamer.sv | 87 ++++++++
 3 files changed

// File: rtl/vga_spi_pkg.sv
// Shared video timing, SPI flash command and streamer FSM encodings.
package vga_spi_pkg;
  localparam int H_VIEW  = 426;
  localparam int H_TOTAL = 550;
  localparam int V_VIEW  = 720;
  localparam int V_TOTAL = 750;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CMD    = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: SCLK at clk/2, MSB-first 32-bit command shift, MISO sample strobe.
// Starts on a single-cycle start pulse; stop or reset returns the bus to idle on the same edge.
module spi_bit_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] load_word,
  output logic        csb,
  output logic        sclk,
  output logic        mosi,
  output logic        sample,
  output logic        cmd_done
);
  logic [31:0] shift_reg;
  logic [5:0]  rise_cnt;
  logic        data_phase;

  // Both strobes mark edges that drive SCLK 1->0.
  assign sample   = !csb && data_phase && sclk;
  assign cmd_done = !csb && !data_phase && sclk && (rise_cnt == 6'd32);

  always_ff @(posedge clk) begin
    if (reset || stop) begin
      csb        <= 1'b1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      shift_reg  <= 32'd0;
      rise_cnt   <= 6'd0;
      data_phase <= 1'b0;
    end else if (start) begin
      csb        <= 1'b0;
      sclk       <= 1'b0;
      mosi       <= load_word[31];
      shift_reg  <= load_word;
      rise_cnt   <= 6'd0;
      data_phase <= 1'b0;
    end else if (!csb) begin
      sclk <= ~sclk;
      if (!sclk) begin
        if (!data_phase) rise_cnt <= rise_cnt + 6'd1;
      end else if (!data_phase) begin
        // Zeros shift in behind the command, so MOSI idles low once streaming.
        shift_reg <= {shift_reg[30:0], 1'b0};
        mosi      <= shift_reg[30];
        if (rise_cnt == 6'd32) data_phase <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_line_streamer.sv
// Streams one 1bpp scanline per line from SPI flash straight to rgb, fetch launched in HBLANK.
// The rgb register looks one pixel ahead so that its value lines up with the current hpos.
module spi_line_streamer
  import vga_spi_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          STRIDE_LOG2 = 5,
  parameter logic [5:0]  FG_COLOR    = 6'b111111,
  parameter int          FETCH_START = H_TOTAL - 67
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       spi_miso,
  output logic       spi_csb,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic [5:0] rgb,
  output logic       busy
);
  logic [1:0]  state;
  logic [9:0]  next_line;
  logic [9:0]  h_next;
  logic [9:0]  v_next;
  logic [23:0] line_addr;
  logic        at_start;
  logic        at_stop;
  logic        start;
  logic        stop;
  logic        sample;
  logic        cmd_done;
  logic        take_bit;
  logic        vis_next;
  logic        pix;
  logic        pix_d;

  assign next_line = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
  assign h_next    = (hpos == 10'(H_TOTAL - 1)) ? 10'd0 : hpos + 10'd1;
  assign v_next    = (hpos == 10'(H_TOTAL - 1)) ? next_line : vpos;
  assign line_addr = BASE_ADDR + (24'(next_line) << STRIDE_LOG2);

  // Stop outranks start if a bad FETCH_START makes them coincide.
  assign at_stop  = (hpos == 10'(H_VIEW));
  assign at_start = (hpos == 10'(FETCH_START)) && (next_line < 10'(V_VIEW));
  assign stop     = at_stop && (state != ST_IDLE);
  assign start    = at_start && !at_stop && (state == ST_IDLE);

  // Only bits that land on a visible pixel pair are taken.
  assign take_bit = sample && !stop && (h_next < 10'(H_VIEW));
  assign pix_d    = take_bit ? spi_miso : pix;
  assign vis_next = (h_next < 10'(H_VIEW)) && (v_next < 10'(V_VIEW));
  assign busy     = !spi_csb;

  always_ff @(posedge clk) begin
    if (reset || stop) begin
      state <= ST_IDLE;
    end else if (start) begin
      state <= ST_CMD;
    end else if (state == ST_CMD && cmd_done) begin
      state <= ST_STREAM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix <= 1'b0;
      rgb <= 6'd0;
    end else begin
      pix <= pix_d;
      rgb <= (pix_d && vis_next) ? FG_COLOR : 6'd0;
    end
  end

  spi_bit_engine u_engine (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .load_word ({SPI_CMD_READ, line_addr}),
    .csb       (spi_csb),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .sample    (sample),
    .cmd_done  (cmd_done)
  );
endmodule
